// File: rtl/global_config_pkg.sv
// ============================================================================
//  Module      : global_config_pkg
//  Description : Shared front-end configuration and interface types.
//                Holds the core address width, the BPU -> FTQ and
//                FTQ <-> ICache handshake structs, and the FTQ sizing types.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package global_config_pkg;

    typedef struct packed {
        int unsigned VLEN;
    } cfg_t;

    localparam cfg_t Cfg = '{VLEN: 32};

    typedef logic [Cfg.VLEN-1:0] vaddr_t;

    // FTQ -> ICache fetch request
    typedef struct packed {
        logic   valid;
        vaddr_t vaddr;
    } ftq2icache_req_t;

    // ICache -> FTQ backpressure
    typedef struct packed {
        logic ready;
    } icache2ftq_rsp_t;

    // BPU -> FTQ predicted fetch target
    typedef struct packed {
        logic   valid;
        vaddr_t vaddr;
    } bpu2ftq_req_t;

    localparam int unsigned FTQ_DEPTH = 8;
    localparam int unsigned FTQ_PTR_W = $clog2(FTQ_DEPTH);

    typedef logic [FTQ_PTR_W-1:0] ftq_idx_t;

endpackage

`default_nettype wire

// File: rtl/ftq_entry_ram.sv
// ============================================================================
//  Module      : ftq_entry_ram
//  Description : DEPTH x WIDTH flop array, one synchronous write port and
//                one asynchronous read port. Contents are not reset.
//  Ports       : clk_i   - clock
//                we_i    - write enable
//                waddr_i - write index
//                wdata_i - write data
//                raddr_i - read index
//                rdata_o - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ftq_entry_ram #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/fetch_target_queue.sv
// ============================================================================
//  Module      : fetch_target_queue
//  Description : Circular queue of fetch-block start addresses between the
//                branch predictor and the instruction cache. Entries are
//                enqueued by the BPU, issued in order to the ICache and held
//                until the IFU retires them. A flush empties the queue.
//  Ports       : clk_i, rst_i  - clock, asynchronous active-high reset
//                bpu_valid_i   - BPU offers a fetch target
//                bpu_vaddr_i   - fetch block start address
//                bpu_ready_o   - queue can accept an entry
//                icache_req_o  - {valid, vaddr} request to the ICache
//                icache_rsp_i  - {ready} from the ICache
//                icache_idx_o  - entry index of the current request (IFU tag)
//                ifu_retire_i  - oldest issued entry is finished
//                flush_i       - discard all entries
//                count_o       - occupied entries, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_target_queue
    import global_config_pkg::*;
#(
    parameter int unsigned DEPTH = FTQ_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            bpu_valid_i,
    input  vaddr_t          bpu_vaddr_i,
    output logic            bpu_ready_o,
    output ftq2icache_req_t icache_req_o,
    input  icache2ftq_rsp_t icache_rsp_i,
    output logic [PTR_W-1:0] icache_idx_o,
    input  logic            ifu_retire_i,
    input  logic            flush_i,
    output logic [PTR_W:0]  count_o
);

    // Pointers carry one extra MSB as a wrap bit so full and empty differ.
    typedef logic [PTR_W:0] ptr_t;

    ptr_t   enq_ptr_q,   enq_ptr_d;
    ptr_t   fetch_ptr_q, fetch_ptr_d;
    ptr_t   deq_ptr_q,   deq_ptr_d;

    logic   full;
    logic   req_valid;
    logic   enq_fire;
    logic   issue_fire;
    logic   retire_fire;
    vaddr_t rd_vaddr;

    always_comb begin
        full        = (enq_ptr_q[PTR_W-1:0] == deq_ptr_q[PTR_W-1:0]) &&
                      (enq_ptr_q[PTR_W] != deq_ptr_q[PTR_W]);
        // Readiness depends on registered state only; a same-cycle retire
        // does not open a slot until the next cycle.
        enq_fire    = bpu_valid_i && !full && !flush_i;
        req_valid   = (fetch_ptr_q != enq_ptr_q) && !flush_i;
        issue_fire  = req_valid && icache_rsp_i.ready;
        retire_fire = ifu_retire_i && (deq_ptr_q != fetch_ptr_q) && !flush_i;

        enq_ptr_d   = enq_ptr_q;
        fetch_ptr_d = fetch_ptr_q;
        deq_ptr_d   = deq_ptr_q;
        if (flush_i) begin
            enq_ptr_d   = '0;
            fetch_ptr_d = '0;
            deq_ptr_d   = '0;
        end else begin
            if (enq_fire)    enq_ptr_d   = enq_ptr_q   + ptr_t'(1);
            if (issue_fire)  fetch_ptr_d = fetch_ptr_q + ptr_t'(1);
            if (retire_fire) deq_ptr_d   = deq_ptr_q   + ptr_t'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enq_ptr_q   <= '0;
            fetch_ptr_q <= '0;
            deq_ptr_q   <= '0;
        end else begin
            enq_ptr_q   <= enq_ptr_d;
            fetch_ptr_q <= fetch_ptr_d;
            deq_ptr_q   <= deq_ptr_d;
        end
    end

    // Entries are never written before retirement, so the read data at
    // fetch_ptr stays stable while the ICache applies backpressure.
    ftq_entry_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (Cfg.VLEN),
        .ADDR_W (PTR_W)
    ) u_entry_ram (
        .clk_i   (clk_i),
        .we_i    (enq_fire),
        .waddr_i (enq_ptr_q[PTR_W-1:0]),
        .wdata_i (bpu_vaddr_i),
        .raddr_i (fetch_ptr_q[PTR_W-1:0]),
        .rdata_o (rd_vaddr)
    );

    always_comb begin
        icache_req_o       = '0;
        icache_req_o.valid = req_valid;
        icache_req_o.vaddr = rd_vaddr;
    end

    assign icache_idx_o = fetch_ptr_q[PTR_W-1:0];
    assign bpu_ready_o  = !full;
    assign count_o      = enq_ptr_q - deq_ptr_q;

`ifndef SYNTHESIS
    // A retire with nothing issued is dropped; flag it in simulation.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && ifu_retire_i) begin
            assert (deq_ptr_q != fetch_ptr_q)
                else $warning("ftq: retire with no issued entry ignored");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_target_queue.sv
// ============================================================================
//  Module      : tb_fetch_target_queue
//  Description : Self-checking bench for fetch_target_queue. A reference
//                pointer model predicts count/ready/valid every cycle and a
//                scoreboard queue predicts the order and tag of issued
//                addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_target_queue;
    import global_config_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            bpu_valid;
    vaddr_t          bpu_vaddr;
    logic            bpu_ready;
    ftq2icache_req_t req;
    icache2ftq_rsp_t rsp;
    logic [2:0]      idx;
    logic            retire;
    logic            flush;
    logic [3:0]      count;

    always #5 clk = ~clk;

    fetch_target_queue #(.DEPTH(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bpu_valid_i  (bpu_valid),
        .bpu_vaddr_i  (bpu_vaddr),
        .bpu_ready_o  (bpu_ready),
        .icache_req_o (req),
        .icache_rsp_i (rsp),
        .icache_idx_o (idx),
        .ifu_retire_i (retire),
        .flush_i      (flush),
        .count_o      (count)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    typedef struct {
        vaddr_t     va;
        logic [2:0] idx;
    } sb_t;
    sb_t sbq[$];

    int m_enq = 0, m_fetch = 0, m_deq = 0;

    logic       s_valid, s_ready;
    vaddr_t     s_vaddr;
    logic [2:0] s_idx;
    logic [3:0] s_count;

    // Ordering invariant: deq <= fetch <= enq in wrapped distance.
    always @(posedge clk) begin
        if (!rst) begin
            assert (4'(dut.fetch_ptr_q - dut.deq_ptr_q) <= 4'(dut.enq_ptr_q - dut.deq_ptr_q))
                else begin
                    errors++;
                    $display("FAIL invariant fetch-deq=%0d enq-deq=%0d",
                             4'(dut.fetch_ptr_q - dut.deq_ptr_q), 4'(dut.enq_ptr_q - dut.deq_ptr_q));
                end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, advance model.
    task automatic cycle(input logic bv, input vaddr_t va, input logic rdy,
                         input logic ret, input logic fl);
        int   e_count;
        logic e_ready, e_valid, do_enq, do_iss, do_ret;
        sb_t  e;
        @(negedge clk);
        bpu_valid = bv; bpu_vaddr = va; rsp.ready = rdy; retire = ret; flush = fl;
        #1;
        e_count = (m_enq - m_deq) & 15;
        e_ready = (e_count != 8);
        e_valid = (m_fetch != m_enq) && !fl;
        chk("count", 64'(count), 64'(e_count));
        chk("bpu_ready", 64'(bpu_ready), 64'(e_ready));
        chk("req_valid", 64'(req.valid), 64'(e_valid));
        s_valid = req.valid; s_vaddr = req.vaddr; s_idx = idx;
        s_ready = bpu_ready; s_count = count;
        do_enq = bv && e_ready && !fl;
        do_iss = e_valid && rdy;
        do_ret = ret && (m_deq != m_fetch) && !fl;
        if (do_iss) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty actual=issue expected=none");
            end else begin
                e = sbq.pop_front();
                chk("issue_vaddr", 64'(req.vaddr), 64'(e.va));
                chk("issue_idx", 64'(idx), 64'(e.idx));
                pops++;
            end
        end
        if (do_enq) begin
            e.va = va; e.idx = 3'(m_enq);
            sbq.push_back(e);
            m_enq = (m_enq + 1) & 15;
        end
        if (do_iss) m_fetch = (m_fetch + 1) & 15;
        if (do_ret) m_deq = (m_deq + 1) & 15;
        if (fl) begin
            m_enq = 0; m_fetch = 0; m_deq = 0;
            sbq.delete();
        end
        @(posedge clk);
    endtask

    typedef struct {
        logic       bv;
        vaddr_t     va;
        logic       rdy, ret, fl;
        logic [3:0] ecnt;
        logic       evalid, erdy;
    } vec_t;

    vec_t vt[5];
    int   p0;
    vaddr_t     v0;
    logic [2:0] i0;

    initial begin
        vt[0] = '{1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vt[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1};
        vt[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1};
        vt[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1};
        vt[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};

        rst = 1'b1; bpu_valid = 1'b0; bpu_vaddr = '0; rsp.ready = 1'b0;
        retire = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bpu_ready), 64'd1);
        chk("rst_valid", 64'(req.valid), 64'd0);
        chk("rst_idx",   64'(idx),       64'd0);
        chk("rst_count", 64'(count),     64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single enqueue: request appears one cycle later, then retires.
        for (int i = 0; i < 5; i++) begin
            cycle(vt[i].bv, vt[i].va, vt[i].rdy, vt[i].ret, vt[i].fl);
            chk("tbl_count", 64'(s_count), 64'(vt[i].ecnt));
            chk("tbl_valid", 64'(s_valid), 64'(vt[i].evalid));
            chk("tbl_ready", 64'(s_ready), 64'(vt[i].erdy));
        end

        // Backpressure: request held stable, then issued in FIFO order.
        p0 = pops;
        cycle(1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hB000_0000, 1'b0, 1'b0, 1'b0);
        v0 = s_vaddr; i0 = s_idx;
        chk("bp_first_vaddr", 64'(v0), 64'hA000_0000);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
            chk("bp_valid", 64'(s_valid), 64'd1);
            chk("bp_vaddr", 64'(s_vaddr), 64'(v0));
            chk("bp_idx",   64'(s_idx),   64'(i0));
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("bp_pops", 64'(pops - p0), 64'd2);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("bp_drained", 64'(s_count), 64'd0);

        // Full queue: 9th offer refused; one retire reopens a slot.
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'hC000_0000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        chk("full_count", 64'(s_count), 64'd8);
        chk("full_ready", 64'(s_ready), 64'd0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("full_ready_retire_cycle", 64'(s_ready), 64'd0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("after_retire_count", 64'(s_count), 64'd7);
        chk("after_retire_ready", 64'(s_ready), 64'd1);
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("full_drained", 64'(s_count), 64'd0);

        // Streaming with issue and retire every cycle; idx wraps twice.
        p0 = pops;
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h0001_0000 + 32'(i * 64), 1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("stream_pops", 64'(pops - p0), 64'd20);
        chk("stream_count", 64'(s_count), 64'd0);

        // Flush while a request is stalled with 5 entries held.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hE000_0000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", 64'(s_count), 64'd5);
        chk("pre_flush_valid", 64'(s_valid), 64'd1);
        cycle(1'b1, 32'hBAD0_0000, 1'b0, 1'b0, 1'b1);
        chk("flush_valid", 64'(s_valid), 64'd0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("post_flush_count", 64'(s_count), 64'd0);
        chk("post_flush_ready", 64'(s_ready), 64'd1);
        chk("post_flush_valid", 64'(s_valid), 64'd0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("post_flush_valid2", 64'(s_valid), 64'd0);

        // Spurious retires: empty queue, then queued but not issued.
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("spurious_retire_empty", 64'(s_count), 64'd0);
        cycle(1'b1, 32'hF000_0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("spurious_retire_unissued", 64'(s_count), 64'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("final_count", 64'(s_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_target_queue.md
Name: fetch_target_queue

Overview:
- Circular queue of fetch-block start addresses, placed between branch prediction and the instruction cache.
- Accepts predicted fetch targets from the BPU over a valid/ready handshake.
- Issues them in order to the ICache as ftq2icache_req_t, with backpressure from icache2ftq_rsp_t.ready.
- Holds each issued entry until the IFU retires it. A backend flush empties the queue.

Parameters:
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- PTR_W, $clog2(DEPTH), entry index width. Internal pointers are PTR_W+1 bits wide; the extra MSB is the wrap bit.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- bpu_valid_i  in  1  BPU offers a fetch target
- bpu_vaddr_i  in  Cfg.VLEN  fetch block start address
- bpu_ready_o  out  1  queue can accept an entry
- icache_req_o  out  $bits(ftq2icache_req_t)  {valid, vaddr} request to the ICache
- icache_rsp_i  in  $bits(icache2ftq_rsp_t)  {ready} from the ICache
- icache_idx_o  out  PTR_W  entry index of the current request, used as a tag by the IFU
- ifu_retire_i  in  1  IFU finished the oldest issued entry
- flush_i  in  1  backend redirect; discard all entries
- count_o  out  PTR_W+1  occupied entries, 0..DEPTH

Behaviour:
- Reset: asynchronous on rst_i high.
  - enq_ptr, fetch_ptr and deq_ptr reset to 0.
  - Outputs during and after reset: bpu_ready_o=1, icache_req_o.valid=0, icache_idx_o=0, count_o=0.
  - Entry storage is not reset; its contents are don't-care.
- Pointer state: empty when enq_ptr==deq_ptr. Full when the indices are equal and the wrap bits differ.
- count_o = enq_ptr - deq_ptr, computed modulo 2^(PTR_W+1).
- bpu_ready_o = !full.
  - It is registered-state only: a retire in the same cycle does not free a slot for that cycle's enqueue.
- Enqueue: when bpu_valid_i && bpu_ready_o && !flush_i, write entry[enq_ptr] and increment enq_ptr.
- Issue:
  - icache_req_o.valid = (fetch_ptr != enq_ptr) && !flush_i.
  - icache_req_o.vaddr = entry[fetch_ptr], and icache_idx_o = fetch_ptr index bits.
  - Enqueue-to-request latency is 1 cycle. There is no same-cycle bypass.
- Handshake:
  - When valid && icache_rsp_i.ready, increment fetch_ptr at the clock edge.
  - While valid && !ready, vaddr and idx must stay stable.
  - Entries are never overwritten before they are retired, so vaddr stability follows from the storage.
- Retire:
  - When ifu_retire_i && (deq_ptr != fetch_ptr) && !flush_i, increment deq_ptr.
  - A retire with no issued entry is ignored and fires a simulation assertion.
- Simultaneous events without flush: enqueue, issue and retire may all occur in the same cycle, and each pointer updates independently.
- Flush:
  - flush_i has highest priority.
  - In the flush cycle, icache_req_o.valid is forced to 0 combinationally, and enqueue and retire are ignored.
  - At the next edge, all three pointers become 0.
  - From the following cycle: count_o=0, bpu_ready_o=1, valid=0.
- Wrap-around: pointers increment modulo 2^(PTR_W+1). Index = low PTR_W bits.
- Invariant: deq_ptr ≤ fetch_ptr ≤ enq_ptr in wrapped-distance terms. The bench checks this with an assertion.

Decomposition:
- global_config_pkg:
  - add localparam FTQ_DEPTH and typedef ftq_idx_t (logic [PTR_W-1:0]);
  - add bpu2ftq_req_t {valid, vaddr};
  - reuse the existing ftq2icache_req_t and icache2ftq_rsp_t.
- Sub-module ftq_entry_ram: DEPTH x Cfg.VLEN flop array with 1 write port and 1 async read port, no reset.
- Pointer logic, handshakes and flush handling stay in fetch_target_queue.

Test Plan:
- Reset, then enqueue 0x8000_0000 at cycle 0 with icache ready=1 → at cycle 1 valid=1, vaddr=0x8000_0000, idx=0; at cycle 2 valid=0, count_o=1.
- ICache ready=0 for 5 cycles with 2 entries queued → valid stays 1 and vaddr/idx stay constant. Raise ready → the 2 entries issue on consecutive cycles in FIFO order.
- Enqueue 8 entries with no retire → count_o=8 and bpu_ready_o=0; a 9th offer is not accepted. One retire → next cycle bpu_ready_o=1 and count_o=7.
- Stream 20 targets with icache ready=1 and a retire each cycle → vaddrs emerge in order, and idx wraps 7→0 twice with no loss or duplication.
- Flush asserted while valid=1, ready=0, count_o=5, together with bpu_valid_i=1 → in the flush cycle valid=0; next cycle count_o=0 and the new target is not stored.
- Assert ifu_retire_i with no issued entries → count_o unchanged and the assertion fires.
